instr_seq_dec: RTL and testbench

- Parametrised successor to the MSP430 instruction decoder.
- Accepts words from the MDB under a valid/ready handshake and classifies each opcode word as Format I, Format II or Jump.
- Works out how many extension words (0-2) the source/destination addressing modes need and captures them into separate source and destination registers.
- Presents one fully decoded instruction to the execute stage under a valid/ready handshake. Drives the PC-increment strobe.

---
 rtl/instr_seq_dec.sv | 206 ++++++++++++++++++++
 tb/tb_instr_seq_dec.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_seq_dec.sv
// rtl/instr_seq_dec.sv - MSP430-style instruction word sequencer and decoder
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   mdb_in/valid/ready       opcode and extension words from the memory data bus
//   pc_inc                   one-cycle strobe per accepted word
//   dec_valid/dec_ready      decoded-instruction handshake towards execute
//   format, opcode, reg_sa, reg_da, as_mode, ad_mode, bw, src_ext, dst_ext,
//   n_ext, jmp_off, illegal  registered decoded fields, stable while dec_valid
module instr_seq_dec #(
    parameter int DW     = 16,
    parameter int RAW    = 4,
    parameter bit CG_EN  = 1'b1,
    parameter int JOFF_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  mdb_in,
    input  logic           mdb_valid,
    output logic           mdb_ready,
    output logic           pc_inc,
    output logic           dec_valid,
    input  logic           dec_ready,
    output logic [1:0]     format,
    output logic [3:0]     opcode,
    output logic [RAW-1:0] reg_sa,
    output logic [RAW-1:0] reg_da,
    output logic [1:0]     as_mode,
    output logic           ad_mode,
    output logic           bw,
    output logic [DW-1:0]  src_ext,
    output logic [DW-1:0]  dst_ext,
    output logic [1:0]     n_ext,
    output logic [DW-1:0]  jmp_off,
    output logic           illegal
);

    typedef enum logic [1:0] {S_OP, S_SRC, S_DST, S_ISSUE} state_e;
    state_e state_q, state_d;

    // Opcode fields always come from the low 16 bits, whatever DW is.
    logic [15:0] w;
    assign w = mdb_in[15:0];

    logic       is_jmp, is_f2, is_f1;
    logic [3:0] src_reg;
    logic [1:0] as_f;
    logic       src_need, dst_need;

    assign is_jmp  = (w[15:13] == 3'b001);
    assign is_f2   = (w[15:10] == 6'b000100) && (w[9:7] != 3'b111);
    assign is_f1   = (w[15:12] >= 4'd4);
    assign src_reg = is_f1 ? w[11:8] : w[3:0];
    assign as_f    = w[5:4];

    // Indexed/symbolic/absolute (As=01) and immediate (@PC+) need a word;
    // R3 is the constant generator and never does when CG_EN is set. R2 with
    // As=10/11 already falls out of the rule below without a special case.
    assign src_need = (is_f1 || is_f2) &&
                      (((as_f == 2'b01) && !(CG_EN && (src_reg == 4'd3))) ||
                       ((as_f == 2'b11) && (src_reg == 4'd0)));
    assign dst_need = is_f1 && w[7];

    logic ld_op, ld_src, ld_dst;
    logic dst_pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_OP;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mdb_ready = 1'b1;
        dec_valid = 1'b0;
        ld_op     = 1'b0;
        ld_src    = 1'b0;
        ld_dst    = 1'b0;
        case (state_q)
            S_OP: begin
                if (mdb_valid) begin
                    ld_op = 1'b1;
                    if (src_need)      state_d = S_SRC;
                    else if (dst_need) state_d = S_DST;
                    else               state_d = S_ISSUE;
                end
            end
            S_SRC: begin
                if (mdb_valid) begin
                    ld_src  = 1'b1;
                    state_d = dst_pend_q ? S_DST : S_ISSUE;
                end
            end
            S_DST: begin
                if (mdb_valid) begin
                    ld_dst  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mdb_ready = 1'b0;
                dec_valid = 1'b1;
                if (dec_ready) state_d = S_OP;
            end
            default: state_d = S_OP;
        endcase
    end

    assign pc_inc = mdb_valid & mdb_ready;

    // Field values decoded from the opcode word; only loaded on the OP accept.
    logic [1:0]     format_d, as_d;
    logic [3:0]     opcode_d;
    logic [RAW-1:0] reg_sa_d, reg_da_d;
    logic           ad_d, bw_d, ill_d;
    logic [DW-1:0]  jmp_d;

    always_comb begin
        format_d = 2'd0;
        opcode_d = 4'd0;
        reg_sa_d = '0;
        reg_da_d = '0;
        as_d     = 2'd0;
        ad_d     = 1'b0;
        bw_d     = 1'b0;
        jmp_d    = '0;
        ill_d    = 1'b0;
        if (is_jmp) begin
            format_d = 2'd3;
            opcode_d = {1'b0, w[12:10]};
            jmp_d    = DW'($signed(mdb_in[JOFF_W-1:0]));
        end else if (is_f2) begin
            format_d = 2'd2;
            opcode_d = {1'b0, w[9:7]};
            reg_da_d = RAW'(w[3:0]);
            as_d     = w[5:4];
            bw_d     = w[6];
        end else if (is_f1) begin
            format_d = 2'd1;
            opcode_d = w[15:12];
            reg_sa_d = RAW'(w[11:8]);
            reg_da_d = RAW'(w[3:0]);
            as_d     = w[5:4];
            ad_d     = w[7];
            bw_d     = w[6];
        end else begin
            ill_d    = 1'b1;
        end
    end

    logic [1:0]     format_q, as_q, n_ext_q;
    logic [3:0]     opcode_q;
    logic [RAW-1:0] reg_sa_q, reg_da_q;
    logic           ad_q, bw_q, ill_q;
    logic [DW-1:0]  src_ext_q, dst_ext_q, jmp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            format_q   <= 2'd0;
            opcode_q   <= 4'd0;
            reg_sa_q   <= '0;
            reg_da_q   <= '0;
            as_q       <= 2'd0;
            ad_q       <= 1'b0;
            bw_q       <= 1'b0;
            ill_q      <= 1'b0;
            jmp_q      <= '0;
            n_ext_q    <= 2'd0;
            dst_pend_q <= 1'b0;
            src_ext_q  <= '0;
            dst_ext_q  <= '0;
        end else begin
            if (ld_op) begin
                format_q   <= format_d;
                opcode_q   <= opcode_d;
                reg_sa_q   <= reg_sa_d;
                reg_da_q   <= reg_da_d;
                as_q       <= as_d;
                ad_q       <= ad_d;
                bw_q       <= bw_d;
                ill_q      <= ill_d;
                jmp_q      <= jmp_d;
                n_ext_q    <= {1'b0, src_need} + {1'b0, dst_need};
                dst_pend_q <= dst_need;
                src_ext_q  <= '0;
                dst_ext_q  <= '0;
            end
            if (ld_src) src_ext_q <= mdb_in;
            if (ld_dst) dst_ext_q <= mdb_in;
        end
    end

    assign format  = format_q;
    assign opcode  = opcode_q;
    assign reg_sa  = reg_sa_q;
    assign reg_da  = reg_da_q;
    assign as_mode = as_q;
    assign ad_mode = ad_q;
    assign bw      = bw_q;
    assign src_ext = src_ext_q;
    assign dst_ext = dst_ext_q;
    assign n_ext   = n_ext_q;
    assign jmp_off = jmp_q;
    assign illegal = ill_q;

endmodule

// File: tb/tb_instr_seq_dec.sv
// tb/tb_instr_seq_dec.sv - bench for instr_seq_dec, CG_EN=1 (index 1) and CG_EN=0 (index 0)
module tb_instr_seq_dec;

    localparam int DW  = 16;
    localparam int RAW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  mdb_in;
    logic           mdb_valid [2];
    logic           dec_ready [2];
    logic           mdb_ready [2];
    logic           pc_inc    [2];
    logic           dec_valid [2];
    logic           ad_mode   [2];
    logic           bw        [2];
    logic           illegal   [2];
    logic [1:0]     format    [2];
    logic [1:0]     as_mode   [2];
    logic [1:0]     n_ext     [2];
    logic [3:0]     opcode    [2];
    logic [RAW-1:0] reg_sa    [2];
    logic [RAW-1:0] reg_da    [2];
    logic [DW-1:0]  src_ext   [2];
    logic [DW-1:0]  dst_ext   [2];
    logic [DW-1:0]  jmp_off   [2];
    int             pc_cnt    [2] = '{0, 0};
    int             vectors = 0;
    int             miscompares = 0;

    always #5 clk = ~clk;

    instr_seq_dec #(.DW(DW), .RAW(RAW), .CG_EN(1'b0), .JOFF_W(10)) u_cg0 (
        .clk(clk), .rst(rst), .mdb_in(mdb_in), .mdb_valid(mdb_valid[0]),
        .mdb_ready(mdb_ready[0]), .pc_inc(pc_inc[0]), .dec_valid(dec_valid[0]),
        .dec_ready(dec_ready[0]), .format(format[0]), .opcode(opcode[0]),
        .reg_sa(reg_sa[0]), .reg_da(reg_da[0]), .as_mode(as_mode[0]),
        .ad_mode(ad_mode[0]), .bw(bw[0]), .src_ext(src_ext[0]), .dst_ext(dst_ext[0]),
        .n_ext(n_ext[0]), .jmp_off(jmp_off[0]), .illegal(illegal[0]));

    instr_seq_dec #(.DW(DW), .RAW(RAW), .CG_EN(1'b1), .JOFF_W(10)) u_cg1 (
        .clk(clk), .rst(rst), .mdb_in(mdb_in), .mdb_valid(mdb_valid[1]),
        .mdb_ready(mdb_ready[1]), .pc_inc(pc_inc[1]), .dec_valid(dec_valid[1]),
        .dec_ready(dec_ready[1]), .format(format[1]), .opcode(opcode[1]),
        .reg_sa(reg_sa[1]), .reg_da(reg_da[1]), .as_mode(as_mode[1]),
        .ad_mode(ad_mode[1]), .bw(bw[1]), .src_ext(src_ext[1]), .dst_ext(dst_ext[1]),
        .n_ext(n_ext[1]), .jmp_off(jmp_off[1]), .illegal(illegal[1]));

    always @(posedge clk) begin
        if (pc_inc[0] === 1'b1) pc_cnt[0] <= pc_cnt[0] + 1;
        if (pc_inc[1] === 1'b1) pc_cnt[1] <= pc_cnt[1] + 1;
    end

    typedef struct {
        int fmt; int opc; int sa; int da; int as_m; int ad; int bw; int ill;
        int nsrc; int ndst; int joff; int sext; int dext;
    } exp_t;

    // Reference decode written with integer arithmetic on the opcode word.
    function automatic exp_t model(input int w, input int cg, input int e1, input int e2);
        exp_t e;
        int   rg;
        e = '{default: 0};
        if ((w / 8192) == 1) begin
            e.fmt  = 3;
            e.opc  = (w / 1024) % 8;
            e.joff = w % 1024;
            if (e.joff >= 512) e.joff = e.joff - 1024 + 65536;
        end else if ((w / 1024) == 4 && ((w / 128) % 8) <= 6) begin
            e.fmt  = 2;
            e.opc  = (w / 128) % 8;
            e.da   = w % 16;
            e.as_m = (w / 16) % 4;
            e.bw   = (w / 64) % 2;
        end else if ((w / 4096) >= 4) begin
            e.fmt  = 1;
            e.opc  = w / 4096;
            e.sa   = (w / 256) % 16;
            e.da   = w % 16;
            e.as_m = (w / 16) % 4;
            e.ad   = (w / 128) % 2;
            e.bw   = (w / 64) % 2;
            e.ndst = e.ad;
        end else begin
            e.ill  = 1;
        end
        if (e.fmt == 1 || e.fmt == 2) begin
            rg = (e.fmt == 1) ? e.sa : e.da;
            if ((e.as_m == 1 && !(cg != 0 && rg == 3)) || (e.as_m == 3 && rg == 0))
                e.nsrc = 1;
        end
        e.sext = (e.nsrc != 0) ? e1 : 0;
        e.dext = (e.ndst != 0) ? ((e.nsrc != 0) ? e2 : e1) : 0;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fields(input int s, input exp_t e, input string tag);
        chk({tag, ".format"},  32'(format[s]),  e.fmt);
        chk({tag, ".opcode"},  32'(opcode[s]),  e.opc);
        chk({tag, ".reg_sa"},  32'(reg_sa[s]),  e.sa);
        chk({tag, ".reg_da"},  32'(reg_da[s]),  e.da);
        chk({tag, ".as_mode"}, 32'(as_mode[s]), e.as_m);
        chk({tag, ".ad_mode"}, 32'(ad_mode[s]), e.ad);
        chk({tag, ".bw"},      32'(bw[s]),      e.bw);
        chk({tag, ".illegal"}, 32'(illegal[s]), e.ill);
        chk({tag, ".n_ext"},   32'(n_ext[s]),   e.nsrc + e.ndst);
        chk({tag, ".src_ext"}, 32'(src_ext[s]), e.sext);
        chk({tag, ".dst_ext"}, 32'(dst_ext[s]), e.dext);
        chk({tag, ".jmp_off"}, 32'(jmp_off[s]), e.joff);
    endtask

    // Feeds one instruction to DUT s, with 'gap' idle cycles before each
    // extension word and 'hold' cycles of dec_ready low while issuing.
    task automatic run_instr(input int s, input int op, input int e1, input int e2,
                             input int gap, input int hold, input string tag);
        exp_t        e;
        int          pc0;
        logic [31:0] r;
        e   = model(op, s, e1, e2);
        pc0 = pc_cnt[s];
        chk({tag, ".rdy_op"}, 32'(mdb_ready[s]), 1);
        mdb_in       = 16'(op);
        mdb_valid[s] = 1'b1;
        step();
        for (int i = 0; i < e.nsrc + e.ndst; i++) begin
            mdb_valid[s] = 1'b0;
            for (int g = 0; g < gap; g++) begin
                step();
                chk({tag, ".gap_dv"},  32'(dec_valid[s]), 0);
                chk({tag, ".gap_rdy"}, 32'(mdb_ready[s]), 1);
                chk({tag, ".gap_fmt"}, 32'(format[s]),    e.fmt);
            end
            mdb_in       = 16'((i == 0) ? e1 : e2);
            mdb_valid[s] = 1'b1;
            step();
        end
        r            = $urandom;
        mdb_in       = r[15:0];
        mdb_valid[s] = 1'b0;
        chk({tag, ".dec_valid"}, 32'(dec_valid[s]), 1);
        chk({tag, ".rdy_issue"}, 32'(mdb_ready[s]), 0);
        chk({tag, ".pc_inc_cnt"}, pc_cnt[s] - pc0, 1 + e.nsrc + e.ndst);
        chk_fields(s, e, tag);
        for (int h = 0; h < hold; h++) begin
            mdb_valid[s] = 1'b1;
            step();
            chk({tag, ".hold_dv"},  32'(dec_valid[s]), 1);
            chk({tag, ".hold_pc"},  32'(pc_inc[s]),    0);
            chk({tag, ".hold_fmt"}, 32'(format[s]),    e.fmt);
            chk({tag, ".hold_src"}, 32'(src_ext[s]),   e.sext);
            chk({tag, ".hold_dst"}, 32'(dst_ext[s]),   e.dext);
            chk({tag, ".hold_jmp"}, 32'(jmp_off[s]),   e.joff);
        end
        mdb_valid[s] = 1'b0;
        dec_ready[s] = 1'b1;
        step();
        dec_ready[s] = 1'b0;
        chk({tag, ".done_dv"},  32'(dec_valid[s]), 0);
        chk({tag, ".done_rdy"}, 32'(mdb_ready[s]), 1);
        chk({tag, ".done_pc"},  pc_cnt[s] - pc0, 1 + e.nsrc + e.ndst);
    endtask

    initial begin
        rst          = 1'b1;
        mdb_in       = '0;
        mdb_valid[0] = 1'b0;
        mdb_valid[1] = 1'b0;
        dec_ready[0] = 1'b0;
        dec_ready[1] = 1'b0;
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            chk("rst.dec_valid", 32'(dec_valid[s]), 0);
            chk("rst.mdb_ready", 32'(mdb_ready[s]), 1);
            chk("rst.format",    32'(format[s]),    0);
            chk("rst.opcode",    32'(opcode[s]),    0);
            chk("rst.src_ext",   32'(src_ext[s]),   0);
            chk("rst.jmp_off",   32'(jmp_off[s]),   0);
            chk("rst.illegal",   32'(illegal[s]),   0);
        end
        rst = 1'b0;
        step();

        run_instr(1, 'h5506, 0, 0, 0, 0, "add_r5_r6");
        chk("add.reg_sa", 32'(reg_sa[1]), 5);
        chk("add.reg_da", 32'(reg_da[1]), 6);
        run_instr(1, 'h4037, 'h1234, 0, 0, 0, "mov_imm");
        chk("mov_imm.src_ext", 32'(src_ext[1]), 'h1234);
        run_instr(1, 'h4495, 'h0002, 'h0004, 2, 0, "mov_idx");
        chk("mov_idx.dst_ext", 32'(dst_ext[1]), 'h0004);
        chk("mov_idx.n_ext",   32'(n_ext[1]),   2);
        run_instr(1, 'h4587, 'h0BEE, 0, 1, 0, "dst_only");
        run_instr(1, 'h4228, 0, 0, 0, 0, "cg1_4228");
        run_instr(0, 'h4228, 0, 0, 0, 0, "cg0_4228");
        chk("cg0_4228.n_ext", 32'(n_ext[0]), 0);
        run_instr(1, 'h4318, 'h55AA, 0, 0, 0, "cg1_4318");
        chk("cg1_4318.n_ext", 32'(n_ext[1]), 0);
        run_instr(0, 'h4318, 'h55AA, 0, 0, 0, "cg0_4318");
        chk("cg0_4318.n_ext", 32'(n_ext[0]), 1);
        run_instr(1, 'h3FFE, 0, 0, 0, 3, "jmp");
        chk("jmp.jmp_off", 32'(jmp_off[1]), 'hFFFE);
        chk("jmp.opcode",  32'(opcode[1]),  7);
        run_instr(1, 'h0000, 0, 0, 0, 0, "illegal");
        chk("illegal.flag", 32'(illegal[1]), 1);
        run_instr(1, 'h1300, 0, 0, 0, 0, "f2_reti");
        run_instr(1, 'h1380, 0, 0, 0, 0, "f2_bad");

        // Reset while waiting for the source extension word.
        mdb_in       = 16'h4037;
        mdb_valid[1] = 1'b1;
        step();
        mdb_valid[1] = 1'b0;
        chk("rstmid.in_src_dv", 32'(dec_valid[1]), 0);
        chk("rstmid.in_src_fmt", 32'(format[1]), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid.dec_valid", 32'(dec_valid[1]), 0);
        chk("rstmid.mdb_ready", 32'(mdb_ready[1]), 1);
        chk("rstmid.format",    32'(format[1]),    0);
        chk("rstmid.opcode",    32'(opcode[1]),    0);
        chk("rstmid.reg_da",    32'(reg_da[1]),    0);
        chk("rstmid.as_mode",   32'(as_mode[1]),   0);
        chk("rstmid.n_ext",     32'(n_ext[1]),     0);
        run_instr(1, 'h5506, 0, 0, 0, 0, "after_rst");

        for (int k = 0; k < 80; k++) begin
            int          s, op, cat, gap, hold;
            logic [31:0] r, r2;
            s    = k % 2;
            cat  = int'($urandom_range(0, 4));
            r    = $urandom;
            r2   = $urandom;
            gap  = int'($urandom_range(0, 2));
            hold = int'($urandom_range(0, 2));
            case (cat)
                0: op = int'($urandom_range(4, 15)) * 4096 + int'(r[11:0]);
                1: op = 'h1000 + int'($urandom_range(0, 6)) * 128 + int'(r[6:0]);
                2: op = 'h2000 + int'(r[12:0]);
                3: op = int'(r[15:0]);
                default: op = int'($urandom_range(4, 15)) * 4096
                              + int'($urandom_range(2, 3)) * 256 + int'(r[7:0]);
            endcase
            run_instr(s, op, int'(r2[15:0]), int'(r2[31:16]), gap, hold, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
